// File: rtl/ex_pkg.sv
// Shared definitions for the EX stage: op encodings, multiplier length, FSM state type.
package ex_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_MEM  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    localparam int unsigned MUL_CYCLES = 32;

    typedef enum logic {StIdle, StBusy} ex_state_e;

    // Single-cycle ALU; MUL is resolved by the caller, so it yields 0 here like OP_RSVD.
    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] imm);
        logic [31:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADDI: r = a + imm;
            OP_MEM:  r = a + imm;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX input payload and EX/MEM output payload of the execute stage.
interface ex_stage_if;

    logic        valid_i;
    logic [2:0]  Op_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [31:0] imm_i;
    logic [4:0]  rsd_i;
    logic        flush_i;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic [31:0] store_data_o;
    logic [4:0]  rsd_o;
    logic [2:0]  Op_o;

    modport master (
        output valid_i, Op_i, rs1_data_i, rs2_data_i, imm_i, rsd_i, flush_i,
        input  stall_o, valid_o, result_o, store_data_o, rsd_o, Op_o
    );

    modport slave (
        input  valid_i, Op_i, rs1_data_i, rs2_data_i, imm_i, rsd_i, flush_i,
        output stall_o, valid_o, result_o, store_data_o, rsd_o, Op_o
    );

endinterface

// File: rtl/ex_mul_iter.sv
// Iterative shift-add 32x32 multiplier (low 32 bits), one multiplier bit per cycle.
module ex_mul_iter
    import ex_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        kill_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] product_o
);

    localparam logic [4:0] LastCount = 5'(MUL_CYCLES - 1);

    ex_state_e   state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] partial;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            count_q <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign partial   = b_q[0] ? a_q : '0;
    // The last bit is folded in combinationally so the product is ready at the final edge.
    assign product_o = acc_q + partial;
    assign busy_o    = (state_q == StBusy);
    assign done_o    = busy_o && (count_q == LastCount);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        if (kill_i) begin
            state_d = StIdle;
            count_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_d = StBusy;
                        count_d = '0;
                        acc_d   = '0;
                        a_d     = a_i;
                        b_d     = b_i;
                    end
                end
                StBusy: begin
                    acc_d = acc_q + partial;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    if (count_q == LastCount) begin
                        state_d = StIdle;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 5'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus MUL. Define EX_STAGE_ITER_MUL_EN to use the
// 32-cycle iterative multiplier (with stall); otherwise MUL is a 1-cycle combinational multiply.
module ex_stage
    import ex_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    ex_stage_if.slave bus
);

    logic        valid_q, valid_d;
    logic [31:0] result_q, result_d;
    logic [31:0] store_q, store_d;
    logic [4:0]  rsd_q, rsd_d;
    logic [2:0]  op_q, op_d;
    logic        is_mul;

    assign is_mul = (bus.Op_i == OP_MUL);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            store_q  <= '0;
            rsd_q    <= '0;
            op_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            store_q  <= store_d;
            rsd_q    <= rsd_d;
            op_q     <= op_d;
        end
    end

`ifdef EX_STAGE_ITER_MUL_EN
    logic        mul_start, mul_busy, mul_done;
    logic [31:0] mul_product;
    logic [4:0]  mul_rsd_q, mul_rsd_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mul_rsd_q <= '0;
        end else begin
            mul_rsd_q <= mul_rsd_d;
        end
    end

    assign mul_start = !bus.flush_i && !mul_busy && bus.valid_i && is_mul;

    ex_mul_iter u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .kill_i    (bus.flush_i),
        .a_i       (bus.rs1_data_i),
        .b_i       (bus.rs2_data_i),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        valid_d   = 1'b0;
        result_d  = result_q;
        store_d   = store_q;
        rsd_d     = rsd_q;
        op_d      = op_q;
        mul_rsd_d = mul_start ? bus.rsd_i : mul_rsd_q;
        if (bus.flush_i) begin
            valid_d = 1'b0;
        end else if (mul_done) begin
            valid_d  = 1'b1;
            result_d = mul_product;
            rsd_d    = mul_rsd_q;
            op_d     = OP_MUL;
        end else if (!mul_busy && bus.valid_i && !is_mul) begin
            valid_d  = 1'b1;
            result_d = alu(bus.Op_i, bus.rs1_data_i, bus.rs2_data_i, bus.imm_i);
            store_d  = bus.rs2_data_i;
            rsd_d    = bus.rsd_i;
            op_d     = bus.Op_i;
        end
    end

    // Drops in the final busy cycle so upstream advances on the same edge the product lands.
    assign bus.stall_o = !bus.flush_i && (mul_start || (mul_busy && !mul_done));
`else
    always_comb begin
        valid_d  = 1'b0;
        result_d = result_q;
        store_d  = store_q;
        rsd_d    = rsd_q;
        op_d     = op_q;
        if (!bus.flush_i && bus.valid_i) begin
            valid_d  = 1'b1;
            result_d = is_mul ? bus.rs1_data_i * bus.rs2_data_i
                              : alu(bus.Op_i, bus.rs1_data_i, bus.rs2_data_i, bus.imm_i);
            store_d  = bus.rs2_data_i;
            rsd_d    = bus.rsd_i;
            op_d     = bus.Op_i;
        end
    end

    assign bus.stall_o = 1'b0;
`endif

    assign bus.valid_o      = valid_q;
    assign bus.result_o     = result_q;
    assign bus.store_data_o = store_q;
    assign bus.rsd_o        = rsd_q;
    assign bus.Op_o         = op_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; expectations follow EX_STAGE_ITER_MUL_EN.
module tb_ex_stage;
    import ex_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic stall_seen;
    logic vseen;

    ex_stage_if bus ();

    ex_stage dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.stall_o === 1'b1) stall_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rsd);
        bus.valid_i    = v;
        bus.Op_i       = op;
        bus.rs1_data_i = a;
        bus.rs2_data_i = b;
        bus.imm_i      = imm;
        bus.rsd_i      = rsd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
        chk({tag, "_result"}, bus.result_o, 32'd0);
        chk({tag, "_store"}, bus.store_data_o, 32'd0);
        chk({tag, "_rsd"}, 32'(bus.rsd_o), 32'd0);
        chk({tag, "_op"}, 32'(bus.Op_o), 32'd0);
        chk({tag, "_stall"}, 32'(bus.stall_o), 32'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        stall_seen = 1'b0;
        bus.flush_i = 1'b0;
        drive(1'b0, OP_ADD, '0, '0, '0, '0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // ADD 5+7
        drive(1'b1, OP_ADD, 32'd5, 32'd7, 32'd0, 5'd1);
        #1 chk("add_stall", 32'(bus.stall_o), 32'd0);
        tick();
        chk("add_result", bus.result_o, 32'd12);
        chk("add_valid", 32'(bus.valid_o), 32'd1);
        chk("add_rsd", 32'(bus.rsd_o), 32'd1);
        chk("add_op", 32'(bus.Op_o), 32'(OP_ADD));
        bus.valid_i = 1'b0;
        tick();
        chk("idle_valid", 32'(bus.valid_o), 32'd0);
        chk("idle_hold", bus.result_o, 32'd12);

        drive(1'b1, OP_SUB, 32'd3, 32'd5, 32'd0, 5'd2);
        tick();
        chk("sub_result", bus.result_o, 32'hFFFF_FFFE);

        drive(1'b1, OP_MEM, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 5'd9);
        tick();
        chk("mem_result", bus.result_o, 32'h0000_00FC);
        chk("mem_store", bus.store_data_o, 32'hDEAD_BEEF);
        chk("mem_op", 32'(bus.Op_o), 32'(OP_MEM));

        drive(1'b1, OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd4);
        tick();
        chk("and_result", bus.result_o, 32'h0000_F000);
        drive(1'b1, OP_OR, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd4);
        tick();
        chk("or_result", bus.result_o, 32'h0000_FFF0);
        drive(1'b1, OP_ADDI, 32'd10, 32'd0, 32'hFFFF_FFFF, 5'd5);
        tick();
        chk("addi_result", bus.result_o, 32'd9);
        drive(1'b1, OP_RSVD, 32'd10, 32'd20, 32'd30, 5'd6);
        tick();
        chk("rsvd_result", bus.result_o, 32'd0);
        chk("rsvd_valid", 32'(bus.valid_o), 32'd1);

        // Flush beats valid on a plain op
        drive(1'b1, OP_ADD, 32'd1, 32'd1, 32'd0, 5'd7);
        bus.flush_i = 1'b1;
        #1 chk("flush_stall", 32'(bus.stall_o), 32'd0);
        tick();
        chk("flush_valid", 32'(bus.valid_o), 32'd0);
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        tick();

`ifdef EX_STAGE_ITER_MUL_EN
        // MUL 6*7: stall T..T+31, valid in T+33
        drive(1'b1, OP_MUL, 32'd6, 32'd7, 32'd0, 5'd3);
        #1 chk("mul_stall_T", 32'(bus.stall_o), 32'd1);
        for (int k = 1; k <= 31; k++) begin
            tick();
            chk("mul_stall_busy", 32'(bus.stall_o), 32'd1);
            chk("mul_valid_busy", 32'(bus.valid_o), 32'd0);
        end
        tick();
        chk("mul_stall_last", 32'(bus.stall_o), 32'd0);
        chk("mul_valid_last", 32'(bus.valid_o), 32'd0);
        bus.valid_i = 1'b0;
        tick();
        chk("mul_valid", 32'(bus.valid_o), 32'd1);
        chk("mul_result", bus.result_o, 32'd42);
        chk("mul_rsd", 32'(bus.rsd_o), 32'd3);
        chk("mul_op", 32'(bus.Op_o), 32'(OP_MUL));
        tick();
        chk("mul_valid_pulse", 32'(bus.valid_o), 32'd0);

        drive(1'b1, OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd8);
        tick();
        bus.valid_i = 1'b0;
        repeat (32) tick();
        chk("mul2_valid", 32'(bus.valid_o), 32'd1);
        chk("mul2_result", bus.result_o, 32'hFFFF_FFFE);

        // Flush mid-MUL at T+10
        drive(1'b1, OP_MUL, 32'd6, 32'd7, 32'd0, 5'd10);
        repeat (10) tick();
        bus.flush_i = 1'b1;
        bus.valid_i = 1'b0;
        #1 chk("mflush_stall", 32'(bus.stall_o), 32'd0);
        tick();
        bus.flush_i = 1'b0;
        chk("mflush_valid", 32'(bus.valid_o), 32'd0);
        #1 chk("mflush_stall_after", 32'(bus.stall_o), 32'd0);
        vseen = 1'b0;
        repeat (30) begin
            tick();
            if (bus.valid_o) vseen = 1'b1;
        end
        chk("mflush_no_valid", 32'(vseen), 32'd0);
        drive(1'b1, OP_ADD, 32'd2, 32'd3, 32'd0, 5'd11);
        #1 chk("mflush_idle_stall", 32'(bus.stall_o), 32'd0);
        tick();
        chk("mflush_idle_add", bus.result_o, 32'd5);
        bus.valid_i = 1'b0;
        tick();

        drive(1'b1, OP_MUL, 32'd6, 32'd7, 32'd0, 5'd12);
        repeat (5) tick();
`else
        // Combinational MUL, latency 1
        drive(1'b1, OP_MUL, 32'd6, 32'd7, 32'd0, 5'd3);
        #1 chk("mul_stall", 32'(bus.stall_o), 32'd0);
        tick();
        chk("mul_valid", 32'(bus.valid_o), 32'd1);
        chk("mul_result", bus.result_o, 32'd42);
        chk("mul_op", 32'(bus.Op_o), 32'(OP_MUL));
        drive(1'b1, OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd8);
        tick();
        chk("mul2_result", bus.result_o, 32'hFFFF_FFFE);
        chk("mul_stall_never", 32'(stall_seen), 32'd0);

        drive(1'b1, OP_MUL, 32'd6, 32'd7, 32'd0, 5'd12);
        tick();
`endif
        // Asynchronous reset during/after a MUL
        rst_n = 1'b0;
        #1 chk_all_zero("mreset");
        bus.valid_i = 1'b0;
        tick();
        rst_n = 1'b1;
        vseen = 1'b0;
        repeat (40) begin
            tick();
            if (bus.valid_o) vseen = 1'b1;
        end
        chk("mreset_no_valid", 32'(vseen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
